// File: rtl/serial_alu_pkg.sv
// Shared encodings for the serial ALU: operation codes and FSM states.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU: AND/OR/sum per bit over a ripple carry chain.
module alu_slice
    import serial_alu_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] ai_i,
    input  logic [SLICE-1:0] bi_i,
    input  logic             c_i,
    input  op_e              op_i,
    output logic [SLICE-1:0] res_o,
    output logic             c_o,
    output logic             cmsb_o
);

    always_comb begin : chain
        logic c;
        c      = c_i;
        res_o  = '0;
        cmsb_o = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                cmsb_o = c;
            end
            case (op_i)
                OP_AND:  res_o[i] = ai_i[i] & bi_i[i];
                OP_OR:   res_o[i] = ai_i[i] | bi_i[i];
                default: res_o[i] = ai_i[i] ^ bi_i[i] ^ c;
            endcase
            // Carry always ripples as a full adder, whatever the operation.
            c = (ai_i[i] & bi_i[i]) | (c & (ai_i[i] ^ bi_i[i]));
        end
        c_o = c;
    end

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle ALU: processes SLICE bits per cycle, LSB first, with
// start/busy/done handshake, signed overflow and full-word SLT.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic             carry_in,
    input  logic [1:0]       operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d, work_shift;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic             zf_q, zf_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [SLICE-1:0] slice_res;
    logic             s_cout, s_cmsb, slt_bit, slice_zero;

    // Operand registers shift right, so the current slice is always at bit 0.
    alu_slice #(.SLICE(SLICE)) u_slice (
        .ai_i   (a_q[SLICE-1:0]),
        .bi_i   (b_q[SLICE-1:0]),
        .c_i    (carry_q),
        .op_i   (op_q),
        .res_o  (slice_res),
        .c_o    (s_cout),
        .cmsb_o (s_cmsb)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        work_d     = work_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        zacc_d     = zacc_q;
        zf_d       = zf_q;
        co_d       = co_q;
        ov_d       = ov_q;
        slice_zero = ~|slice_res;
        slt_bit    = slice_res[SLICE-1] ^ s_cmsb ^ s_cout;
        work_shift = (work_q >> SLICE)
                   | (WIDTH'(slice_res) << (WIDTH - SLICE));
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a ^ {WIDTH{a_invert}};
                    b_d     = b ^ {WIDTH{b_invert}};
                    op_d    = op_e'(operation);
                    carry_d = carry_in;
                    cnt_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                work_d  = work_shift;
                carry_d = s_cout;
                zacc_d  = zacc_q & slice_zero;
                if (cnt_q == CW'(NSLICE - 1)) begin
                    state_d = S_DONE;
                    co_d    = s_cout;
                    ov_d    = s_cmsb ^ s_cout;
                    if (op_q == OP_SLT) begin
                        result_d = WIDTH'(slt_bit);
                        zf_d     = ~slt_bit;
                    end else begin
                        result_d = work_shift;
                        zf_d     = zacc_q & slice_zero;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            zf_q     <= 1'b0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            zf_q     <= zf_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign zf        = zf_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

endmodule
